// File: rtl/i2c_pattern_matcher.sv
// Passive I2C sequence detector: after each START, compares bus bits (ACKs included) to PATTERN/MASK.
// Define I2C_MATCH_CAPTURE_EN to build the capture shift register; otherwise capture is tied to 0.
module i2c_pattern_matcher #(
   parameter int unsigned              PATTERN_BITS = 9,
   parameter logic [PATTERN_BITS-1:0] PATTERN      = 9'h140,
   parameter logic [PATTERN_BITS-1:0] MASK         = 9'h1FF,
   parameter int unsigned              SYNC_STAGES  = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  sda,
   input  logic                                  scl,
   output logic                                  match,
   output logic                                  mismatch,
   output logic                                  abort,
   output logic                                  busy,
   output logic [$clog2(PATTERN_BITS+1)-1:0]     bit_cnt,
   output logic [PATTERN_BITS-1:0]               capture
);

   localparam int unsigned CW = $clog2(PATTERN_BITS+1);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] SHIFT     = 2'd1;
   localparam logic [1:0] WAIT_STOP = 2'd2;

   logic [1:0]             state;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic [SYNC_STAGES-1:0] scl_sync;
   logic                   sda_hist;
   logic                   scl_hist;
   logic                   sda_s;
   logic                   scl_s;
   logic                   ev_start;
   logic                   ev_stop;
   logic                   ev_bit;
   logic                   ev_val;
   logic [CW-1:0]          idx;
   logic                   bit_diff;
   logic                   last_bit;

   assign sda_s = sda_sync[SYNC_STAGES-1];
   assign scl_s = scl_sync[SYNC_STAGES-1];

   // Synchroniser and history reset to the idle bus level so reset never fakes a START.
   always_ff @(posedge clk) begin
      if (reset) begin
         sda_sync <= '1;
         scl_sync <= '1;
         sda_hist <= 1'b1;
         scl_hist <= 1'b1;
      end else begin
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_hist <= sda_s;
         scl_hist <= scl_s;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ev_start <= 1'b0;
         ev_stop  <= 1'b0;
         ev_bit   <= 1'b0;
         ev_val   <= 1'b0;
      end else begin
         ev_start <= scl_s &  sda_hist & ~sda_s;
         ev_stop  <= scl_s & ~sda_hist &  sda_s;
         ev_bit   <= ~scl_hist & scl_s;
         ev_val   <= sda_s;
      end
   end

   assign idx      = CW'(PATTERN_BITS - 1) - bit_cnt;
   assign bit_diff = MASK[idx] && (ev_val != PATTERN[idx]);
   assign last_bit = (bit_cnt == CW'(PATTERN_BITS - 1));
   assign busy     = (state != IDLE);

   // Priority START > STOP > BIT is encoded by the if/else chain order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         match    <= 1'b0;
         mismatch <= 1'b0;
         abort    <= 1'b0;
      end else begin
         match    <= 1'b0;
         mismatch <= 1'b0;
         abort    <= 1'b0;
         if (ev_start) begin
            state   <= SHIFT;
            bit_cnt <= '0;
         end else if (ev_stop) begin
            abort <= (state == SHIFT);
            state <= IDLE;
         end else if (ev_bit && state == SHIFT) begin
            if (bit_diff) begin
               mismatch <= 1'b1;
               state    <= WAIT_STOP;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
               if (last_bit) begin
                  match <= 1'b1;
                  state <= WAIT_STOP;
               end
            end
         end
      end
   end

`ifdef I2C_MATCH_CAPTURE_EN
   logic [PATTERN_BITS-1:0] shreg;
   logic [PATTERN_BITS-1:0] shreg_next;

   assign shreg_next = (shreg << 1) | PATTERN_BITS'(ev_val);

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         capture <= '0;
      end else if (ev_start) begin
         shreg <= '0;
      end else if (!ev_stop && ev_bit && state == SHIFT) begin
         shreg <= shreg_next;
         if (!bit_diff && last_bit)
            capture <= shreg_next;
      end
   end
`else
   assign capture = '0;
`endif

endmodule

// File: tb/tb_i2c_pattern_matcher.sv
// Randomised bench for i2c_pattern_matcher: pin-level stimulus, queue-based reference model, scoreboard monitor.
module tb_i2c_pattern_matcher;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sda = 1'b1;
   logic scl = 1'b1;

   logic       m0, mm0, ab0, b0;
   logic [3:0] bc0;
   logic [8:0] cap0;
   logic       m1, mm1, ab1, b1;
   logic [3:0] bc1;
   logic [8:0] cap1;

   i2c_pattern_matcher dut0 (
      .clk(clk), .reset(reset), .sda(sda), .scl(scl),
      .match(m0), .mismatch(mm0), .abort(ab0), .busy(b0), .bit_cnt(bc0), .capture(cap0)
   );

   i2c_pattern_matcher #(.MASK(9'h1FE)) dut1 (
      .clk(clk), .reset(reset), .sda(sda), .scl(scl),
      .match(m1), .mismatch(mm1), .abort(ab1), .busy(b1), .bit_cnt(bc1), .capture(cap1)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   localparam logic [8:0] PAT = 9'h140;
   localparam int LAT = 4;

   typedef struct {
      int         kind;   // 1 match, 2 mismatch, 3 abort
      int         cnt;
      logic [8:0] cap;
      longint     cyc;
   } exp_t;

   exp_t       q0[$];
   exp_t       q1[$];
   logic [8:0] mask_m [2];
   int         active [2];
   int         done   [2];
   int         nb     [2];
   logic [8:0] sh     [2];
   logic [8:0] last_cap [2];

   // ---------------- reference model (frame-level rules) ----------------
   function automatic void push(input int k, input int kind, input int cnt, input logic [8:0] cap);
      exp_t e;
      e.kind = kind;
      e.cnt  = cnt;
      e.cap  = cap;
      e.cyc  = cyc + LAT;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   function automatic void m_start();
      for (int k = 0; k < 2; k++) begin
         active[k] = 1; done[k] = 0; nb[k] = 0; sh[k] = '0;
      end
   endfunction

   function automatic void m_stop();
      for (int k = 0; k < 2; k++) begin
         if (active[k] != 0 && done[k] == 0) push(k, 3, nb[k], '0);
         active[k] = 0;
      end
   endfunction

   function automatic void m_bit(input logic b);
      int i;
      logic [8:0] c;
      for (int k = 0; k < 2; k++) begin
         if (active[k] != 0 && done[k] == 0) begin
            i = nb[k];
            if (mask_m[k][8-i] && b != PAT[8-i]) begin
               push(k, 2, i, '0);
               done[k] = 1;
            end else begin
               sh[k] = {sh[k][7:0], b};
               nb[k] = nb[k] + 1;
               if (nb[k] == 9) begin
`ifdef I2C_MATCH_CAPTURE_EN
                  c = sh[k];
`else
                  c = '0;
`endif
                  push(k, 1, 9, c);
                  done[k] = 1;
               end
            end
         end
      end
   endfunction

   // ---------------- pin-level stimulus ----------------
   task automatic hold();
      repeat ($urandom_range(4, 7)) @(negedge clk);
   endtask

   task automatic set_sda(input logic v);
      if (scl && v != sda) begin
         if (!v) m_start();
         else    m_stop();
      end
      sda = v;
      hold();
   endtask

   task automatic set_scl(input logic v);
      if (v && !scl) m_bit(sda);
      scl = v;
      hold();
   endtask

   task automatic send_start();
      if (!(scl && sda)) begin
         set_scl(1'b0);
         set_sda(1'b1);
         set_scl(1'b1);
      end
      set_sda(1'b0);
   endtask

   task automatic send_stop();
      set_scl(1'b0);
      set_sda(1'b0);
      set_scl(1'b1);
      set_sda(1'b1);
   endtask

   task automatic send_bit(input logic b);
      set_scl(1'b0);
      set_sda(b);
      set_scl(1'b1);
   endtask

   task automatic send_bits(input logic [8:0] v, input int n);
      for (int j = 0; j < n; j++) send_bit(v[8-j]);
   endtask

   task automatic do_reset();
      if (scl) set_scl(1'b0);
      reset = 1'b1;
      active[0] = 0;
      active[1] = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      hold();
   endtask

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   function automatic int qsize(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qpop(input int k);
      return (k == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   function automatic longint qfront_cyc(input int k);
      return (k == 0) ? q0[0].cyc : q1[0].cyc;
   endfunction

   task automatic mon(input int k, input logic m, input logic mm, input logic ab,
                      input logic [3:0] bc, input logic [8:0] cap);
      int   kind;
      exp_t e;
      kind = m ? 1 : (mm ? 2 : (ab ? 3 : 0));
      if (kind != 0) begin
         total++;
         if ((int'(m) + int'(mm) + int'(ab)) > 1) begin
            bad++;
            $display("FAIL exclusive inst%0d: got m=%0b mm=%0b ab=%0b expected one pulse", k, m, mm, ab);
         end else if (qsize(k) == 0) begin
            bad++;
            $display("FAIL unexpected_pulse inst%0d: got kind=%0d at cyc %0d expected none", k, kind, cyc);
         end else begin
            e = qpop(k);
            if (e.kind == 1) last_cap[k] = e.cap;
            if (e.kind != kind || e.cnt != int'(bc) || e.cyc != cyc || (kind == 1 && e.cap != cap)) begin
               bad++;
               $display("FAIL pulse inst%0d: got kind=%0d cnt=%0d cap=%h cyc=%0d expected kind=%0d cnt=%0d cap=%h cyc=%0d",
                        k, kind, bc, cap, cyc, e.kind, e.cnt, e.cap, e.cyc);
            end
         end
      end else if (qsize(k) > 0 && qfront_cyc(k) < cyc) begin
         e = qpop(k);
         total++;
         bad++;
         $display("FAIL missing_pulse inst%0d: got none expected kind=%0d at cyc %0d", k, e.kind, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      mon(0, m0, mm0, ab0, bc0, cap0);
      mon(1, m1, mm1, ab1, bc1, cap1);
   end

   initial begin
      #600000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [8:0] frame;
      int         len;
      mask_m[0] = 9'h1FF;
      mask_m[1] = 9'h1FE;
      for (int k = 0; k < 2; k++) begin
         active[k] = 0; done[k] = 0; nb[k] = 0; sh[k] = '0; last_cap[k] = '0;
      end

      repeat (4) @(negedge clk);
      chk("reset_match",    int'(m0),   0);
      chk("reset_mismatch", int'(mm0),  0);
      chk("reset_abort",    int'(ab0),  0);
      chk("reset_busy",     int'(b0),   0);
      chk("reset_bit_cnt",  int'(bc0),  0);
      chk("reset_capture",  int'(cap0), 0);
      reset = 1'b0;
      hold();

      // Default pattern matches
      send_start();
      repeat (2) @(negedge clk);
      chk("busy_in_frame", int'(b0), 1);
      send_bits(PAT, 9);
      send_stop();
      repeat (2) @(negedge clk);
      chk("busy_after_stop", int'(b0), 0);

      // Early mismatch, trailing bits ignored
      send_start();
      send_bits(9'h1A5, 9);
      send_stop();

      // ACK=1: strict mask mismatches, relaxed mask matches
      send_start();
      send_bits(9'h141, 9);
      send_stop();

      // Short frame aborted by STOP
      send_start();
      send_bits(PAT, 4);
      send_stop();
      repeat (2) @(negedge clk);
      chk("busy_after_abort", int'(b1), 0);

      // Mismatch, repeated START, then a good frame
      send_start();
      send_bits(9'h000, 3);
      send_start();
      send_bits(PAT, 9);
      send_stop();

      // Reset mid-frame: rest of frame ignored, next frame matches
      send_start();
      send_bits(PAT, 5);
      do_reset();
      chk("midreset_busy",    int'(b0),  0);
      chk("midreset_bit_cnt", int'(bc0), 0);
      for (int j = 5; j < 9; j++) send_bit(PAT[8-j]);
      send_stop();
      send_start();
      send_bits(PAT, 9);
      send_stop();

      // Randomised frames
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(0, 11);
         send_start();
         for (int j = 0; j < len; j++) begin
            frame = PAT;
            if (j < 9 && $urandom_range(0, 99) < 88) send_bit(frame[8-j]);
            else                                      send_bit(1'($urandom_range(0, 1)));
         end
         if ($urandom_range(0, 14) == 0) do_reset();
         else if ($urandom_range(0, 3) != 0) send_stop();
      end
      send_stop();

      repeat (12) @(negedge clk);
      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);
      chk("capture0_hold", int'(cap0), int'(last_cap[0]));
      chk("capture1_hold", int'(cap1), int'(last_cap[1]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_pattern_matcher.md
# i2c_pattern_matcher

Clocked, parametrised I2C bus sequence detector for passive monitoring. It oversamples the raw `sda`/`scl` lines and tracks START/STOP conditions. After each START it compares the clocked-in bit stream, ACK bits included, against a compile-time pattern with a per-bit don't-care mask. It replaces the unclocked fixed-pattern I2C recognisers and sits beside the bus pins as a trigger source for the debug/capture logic.

## Interface
- `PATTERN_BITS`, 9: number of bus bits compared after START, MSB first; range 1..64.
- `PATTERN`, 9'h140: expected bits (default is address 0x50, write, then ACK=0).
- `MASK`, 9'h1FF: 1 = compare this bit, 0 = don't care.
- `SYNC_STAGES`, 2: synchroniser depth on `sda`/`scl`; minimum 2.
- `clk` input 1: system clock; must be at least 8× the `scl` frequency.
- `reset` input 1: synchronous, active-high reset.
- `sda` input 1: raw bus data, asynchronous to `clk`.
- `scl` input 1: raw bus clock, asynchronous to `clk`.
- `match` output 1: one-cycle pulse when all `PATTERN_BITS` bits match.
- `mismatch` output 1: one-cycle pulse on the first compared bit that differs.
- `abort` output 1: one-cycle pulse when STOP arrives before the pattern completes.
- `busy` output 1: high in any state other than IDLE.
- `bit_cnt` output $clog2(PATTERN_BITS+1): number of bits sampled since the last START.
- `capture` output PATTERN_BITS: last fully matched bit sequence (see Configuration).

## Operation
- Synchroniser: `SYNC_STAGES` flops per line, then one history flop for edge detection. Synchroniser and history flops reset to 1, the idle bus level, so no START is falsely seen after reset.
- Events, evaluated on the synchronised signals:
  - START: `scl`=1 while `sda` goes 1→0.
  - STOP: `scl`=1 while `sda` goes 0→1.
  - BIT: `scl` goes 0→1; the synchronised `sda` in that cycle is the sampled bit.
- Event priority: `reset` > START > STOP > BIT.
- States are IDLE, SHIFT, WAIT_STOP.
- IDLE:
  - START → SHIFT, `bit_cnt`=0.
  - All other events are ignored.
- SHIFT, on BIT (let i = `bit_cnt`):
  - If `MASK[PATTERN_BITS-1-i]`=1 and the bit ≠ `PATTERN[PATTERN_BITS-1-i]`: pulse `mismatch`, go to WAIT_STOP.
  - Otherwise, if i = `PATTERN_BITS-1`: pulse `match`, go to WAIT_STOP.
  - Otherwise: increment `bit_cnt`.
  - The shift register takes every sampled bit, compared or not.
- SHIFT, on STOP: pulse `abort`, go to IDLE.
- WAIT_STOP:
  - BIT events are ignored; `bit_cnt` holds.
  - STOP → IDLE with no pulse.
- Repeated START in SHIFT or WAIT_STOP → SHIFT, `bit_cnt`=0, shift register cleared, no pulse.
- `bit_cnt` saturates at `PATTERN_BITS` and clears only on START or reset.
- `match`, `mismatch` and `abort` are mutually exclusive, with at most one pulse per START.

## Timing
- Pin edge to internal event: `SYNC_STAGES`+1 clk.
- Event to output pulse or state change: registered, 1 clk later.
- Total pin-to-`match` latency: `SYNC_STAGES`+2 clk, counted from the final `scl` rising edge.
- Reset values: state IDLE, `match`=`mismatch`=`abort`=`busy`=0, `bit_cnt`=0, `capture`=0.
- Reset mid-frame returns to IDLE in the next cycle with no pulse. A frame already in progress is not recognised until the next START.
- An `sda` change while `scl`=1, other than START/STOP, cannot occur on a legal bus. It is treated as START or STOP by the rules above.

## Configuration
- `I2C_MATCH_CAPTURE_EN` defined:
  - A `PATTERN_BITS` shift register records every sampled bit.
  - On `match`, the full sequence is copied into `capture`, in the same cycle as the pulse.
  - `capture` holds until the next match or reset.
- Not defined: `capture` is tied to 0 and the capture register is not built. All other behaviour is identical.

## Test plan
- Defaults: START, bits 1,0,1,0,0,0,0,0,0 → `match` pulses once, 4 clk after the 9th `scl` rise; `bit_cnt`=9; `capture`=9'h140 with the macro defined, 0 without. STOP → `busy`=0.
- START, bits 1,1 → `mismatch` on the 2nd bit with `bit_cnt`=1. The remaining bits give no further pulse. STOP → IDLE.
- `MASK`=9'h1FE, ACK bit sent as 1 → `match` still pulses.
- START, 4 bits, STOP → `abort` pulses once; `busy`=0 one clk later.
- START, 3 mismatching bits, repeated START, then the correct 9 bits → `mismatch` pulses once, then `match`.
- `reset` asserted after bit 5, released, remaining bits sent → no pulse. The next START plus the pattern gives `match`.
